// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter.
package uart_pkg;

  localparam int SYS_CLK_FREQ          = 125000000;
  localparam int BAUD_RATE             = 115200;
  localparam int BAUD_LENGTH_IN_CYCLES = SYS_CLK_FREQ / BAUD_RATE;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic [IW-1:0] cand;

  // Scan ptr+1, ptr+2, ... so the last owner is considered last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART serializer among N_REQ requesters with
// per-packet round-robin locking and an owner-stall watchdog.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ARB_IDLE   | no owner; picks the next requester, nothing passes
//   ARB_LOCKED | grant_id owns the serializer until its last byte or
//              | until it sits idle long enough to be forcibly released
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 21700
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic [8*N_REQ-1:0]          req_data,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [idx_width(N_REQ)-1:0] grant_id,
  output logic                        busy,
  output logic                        timeout_pulse
);

  localparam int            IW     = idx_width(N_REQ);
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit            TO_EN  = (TIMEOUT_CYCLES > 0);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse_q, pulse_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          locked;
  logic          own_valid;
  logic          own_last;
  logic          xfer;
  logic          expired;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign locked    = (state_q == ARB_LOCKED);
  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign tx_data   = req_data[{grant_q, 3'b000} +: 8];
  assign tx_valid  = locked && own_valid;
  assign xfer      = tx_valid && tx_ready;
  // A byte accepted on the expiry cycle wins over the watchdog.
  assign expired   = TO_EN && (timer_q == T_LAST) && !xfer;

  // Route the serializer's ready back to the owner only.
  always_comb begin
    req_ready = '0;
    if (locked) req_ready[grant_q] = tx_ready;
  end

  // Next-state: grant in IDLE, release on last byte or watchdog expiry.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          timer_d = '0;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (xfer && own_last) begin
          state_d = ARB_IDLE;
          ptr_d   = grant_q;
        end else if (expired) begin
          state_d = ARB_IDLE;
          ptr_d   = grant_q;
          pulse_d = 1'b1;
        end else if (xfer) begin
          timer_d = '0;
        end else if (!own_valid && (timer_q != T_LAST)) begin
          // Only owner-idle cycles count; serializer backpressure does not.
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  assign grant_id      = grant_q;
  assign busy          = locked;
  assign timeout_pulse = pulse_q;

endmodule
